// File: rtl/axi_aw_route_mux.sv
`default_nettype none
// ============================================================================
// Module   : axi_aw_route_mux
// Purpose  : Per-slave-port AW/W routing stage behind a one-hot arbiter.
//            Locks the arbiter's combinational grant into a stable AW
//            selection, forwards the chosen master's AW beat to the slave,
//            returns accept to the arbiter and queues the granted master
//            index in a route FIFO that steers W bursts in AW order.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            gnt / accept        - one-hot grant in, AW-handshake accept out
//            s_aw* / m_aw*       - per-master AW in, single AW out to slave
//            s_w*  / m_w*        - per-master W in, single W out to slave
//            outstanding         - route FIFO occupancy (registered)
// Revision : 1.0 - initial release
// ============================================================================
module axi_aw_route_mux #(
  parameter int N      = 4,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N-1:0]                  gnt,
  output logic                          accept,
  input  logic [N-1:0]                  s_awvalid,
  output logic [N-1:0]                  s_awready,
  input  logic [N*ID_W-1:0]             s_awid,
  input  logic [N*ADDR_W-1:0]           s_awaddr,
  input  logic [N*8-1:0]                s_awlen,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [IDX_W+ID_W-1:0]         m_awid,
  output logic [ADDR_W-1:0]             m_awaddr,
  output logic [7:0]                    m_awlen,
  input  logic [N-1:0]                  s_wvalid,
  output logic [N-1:0]                  s_wready,
  input  logic [N*DATA_W-1:0]           s_wdata,
  input  logic [N*(DATA_W/8)-1:0]       s_wstrb,
  input  logic [N-1:0]                  s_wlast,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic [DATA_W-1:0]             m_wdata,
  output logic [DATA_W/8-1:0]           m_wstrb,
  output logic                          m_wlast,
  output logic [$clog2(DEPTH+1)-1:0]    outstanding
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   fifo_q [DEPTH];

  logic [IDX_W-1:0]   gnt_idx;
  logic               locked;
  logic               w_have;
  logic [IDX_W-1:0]   wsel;
  logic               push;
  logic               pop;

  // Lowest set bit wins so a malformed multi-hot grant still picks one master.
  always_comb begin
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (gnt[i]) gnt_idx = IDX_W'(i);
    end
  end

  // ---------------------------------------------------------------- AW path
  // Every handshake-bearing output is qualified by rst_n so nothing is
  // presented while reset is asserted, even before the first reset edge.
  assign locked    = (state_q == ST_LOCKED) && rst_n;
  assign m_awvalid = locked && s_awvalid[sel_q];
  assign accept    = m_awvalid && m_awready;
  assign push      = accept;

  assign m_awid   = {sel_q, s_awid[sel_q*ID_W +: ID_W]};
  assign m_awaddr = s_awaddr[sel_q*ADDR_W +: ADDR_W];
  assign m_awlen  = s_awlen[sel_q*8 +: 8];

  always_comb begin
    s_awready = '0;
    if (locked) s_awready[sel_q] = m_awready;
  end

  // ----------------------------------------------------------------- W path
  // W follows the FIFO head only; with nothing queued all W is held off.
  assign w_have   = (count_q != '0) && rst_n;
  assign wsel     = fifo_q[rptr_q];
  assign m_wvalid = w_have && s_wvalid[wsel];
  assign m_wdata  = s_wdata[wsel*DATA_W +: DATA_W];
  assign m_wstrb  = s_wstrb[wsel*STRB_W +: STRB_W];
  assign m_wlast  = s_wlast[wsel];
  assign pop      = m_wvalid && m_wready && m_wlast;

  always_comb begin
    s_wready = '0;
    if (w_have) s_wready[wsel] = m_wready;
  end

  assign outstanding = rst_n ? count_q : '0;

  // ------------------------------------------------------ next-state logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        // Latching only with a free slot guarantees the single push this
        // lock produces can never overflow the FIFO.
        if ((gnt != '0) && (count_q < CNT_W'(DEPTH))) begin
          sel_d   = gnt_idx;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= sel_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_aw_route_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_aw_route_mux
// Purpose  : Directed self-checking bench for axi_aw_route_mux (N=4,
//            ID_W=4, ADDR_W=32, DATA_W=32, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_aw_route_mux;

  localparam int N      = 4;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int IDX_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N-1:0]             gnt;
  logic                     accept;
  logic [N-1:0]             s_awvalid;
  logic [N-1:0]             s_awready;
  logic [N*ID_W-1:0]        s_awid;
  logic [N*ADDR_W-1:0]      s_awaddr;
  logic [N*8-1:0]           s_awlen;
  logic                     m_awvalid;
  logic                     m_awready;
  logic [IDX_W+ID_W-1:0]    m_awid;
  logic [ADDR_W-1:0]        m_awaddr;
  logic [7:0]               m_awlen;
  logic [N-1:0]             s_wvalid;
  logic [N-1:0]             s_wready;
  logic [N*DATA_W-1:0]      s_wdata;
  logic [N*DATA_W/8-1:0]    s_wstrb;
  logic [N-1:0]             s_wlast;
  logic                     m_wvalid;
  logic                     m_wready;
  logic [DATA_W-1:0]        m_wdata;
  logic [DATA_W/8-1:0]      m_wstrb;
  logic                     m_wlast;
  logic [2:0]               outstanding;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_aw_route_mux #(
    .N(N), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gnt(gnt), .accept(accept),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast), .outstanding(outstanding)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    gnt = '0; s_awvalid = '0; s_awid = '0; s_awaddr = '0; s_awlen = '0;
    m_awready = 1'b0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0;
    s_wlast = '0; m_wready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One AW transfer from master m: grant in IDLE, handshake in the LOCKED cycle.
  task automatic do_aw(input int m, input logic [3:0] id, input logic [31:0] addr,
                       input logic [7:0] len);
    gnt = 4'(1 << m);
    s_awvalid = 4'(1 << m);
    s_awid[m*ID_W +: ID_W] = id;
    s_awaddr[m*ADDR_W +: ADDR_W] = addr;
    s_awlen[m*8 +: 8] = len;
    m_awready = 1'b1;
    tick();
    gnt = '0;
    #1;
    check_eq($sformatf("aw%0d_accept", m), 64'(accept), 64'd1);
    check_eq($sformatf("aw%0d_awid", m), 64'(m_awid), 64'({2'(m), id}));
    tick();
    s_awvalid = '0;
    m_awready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // ---- Reset state, including while reset is held
    tick();
    check_eq("rst_accept", 64'(accept), 64'd0);
    check_eq("rst_s_awready", 64'(s_awready), 64'd0);
    check_eq("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    check_eq("rst_m_wvalid", 64'(m_wvalid), 64'd0);
    check_eq("rst_s_wready", 64'(s_wready), 64'd0);
    check_eq("rst_outstanding", 64'(outstanding), 64'd0);
    rst_n = 1'b1;

    // ---- Single AW from master 2
    gnt = 4'b0100; s_awvalid = 4'b0100; m_awready = 1'b1;
    s_awid[2*ID_W +: ID_W] = 4'hA;
    s_awaddr[2*ADDR_W +: ADDR_W] = 32'h1234_5678;
    s_awlen[2*8 +: 8] = 8'd7;
    #1;
    check_eq("t1_idle_awvalid", 64'(m_awvalid), 64'd0);
    tick();
    gnt = '0;
    #1;
    check_eq("t1_awvalid", 64'(m_awvalid), 64'd1);
    check_eq("t1_awid", 64'(m_awid), 64'h2A);
    check_eq("t1_awaddr", 64'(m_awaddr), 64'h1234_5678);
    check_eq("t1_awlen", 64'(m_awlen), 64'd7);
    check_eq("t1_accept", 64'(accept), 64'd1);
    check_eq("t1_s_awready", 64'(s_awready), 64'b0100);
    tick();
    check_eq("t1_outstanding", 64'(outstanding), 64'd1);
    check_eq("t1_accept_drop", 64'(accept), 64'd0);

    // ---- Master 1 locked while slave stalls; grant moves to master 3
    do_reset();
    gnt = 4'b0010; s_awvalid = 4'b0010; m_awready = 1'b0;
    s_awid[1*ID_W +: ID_W] = 4'h5;
    s_awid[3*ID_W +: ID_W] = 4'h7;
    tick();
    gnt = 4'b1000; s_awvalid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("t2_stall_awid", 64'(m_awid), 64'h15);
      check_eq("t2_stall_s_awready", 64'(s_awready), 64'd0);
      check_eq("t2_stall_accept", 64'(accept), 64'd0);
      tick();
    end
    m_awready = 1'b1;
    #1;
    check_eq("t2_accept", 64'(accept), 64'd1);
    check_eq("t2_s_awready", 64'(s_awready), 64'b0010);
    check_eq("t2_awid", 64'(m_awid), 64'h15);
    gnt = '0;
    tick();
    check_eq("t2_idle_accept", 64'(accept), 64'd0);
    check_eq("t2_idle_awvalid", 64'(m_awvalid), 64'd0);
    check_eq("t2_outstanding", 64'(outstanding), 64'd1);

    // ---- Fill the FIFO, fifth grant blocked until a W burst retires
    do_reset();
    for (int m = 0; m < 4; m++) do_aw(m, 4'(m + 1), 32'h100 * m, 8'd0);
    check_eq("t3_full", 64'(outstanding), 64'd4);
    gnt = 4'b0001; s_awvalid = 4'b0001; m_awready = 1'b1;
    s_awid[0 +: ID_W] = 4'hC;
    tick();
    check_eq("t3_blocked_awvalid_a", 64'(m_awvalid), 64'd0);
    check_eq("t3_blocked_accept_a", 64'(accept), 64'd0);
    tick();
    check_eq("t3_blocked_awvalid_b", 64'(m_awvalid), 64'd0);
    s_wvalid = 4'b0001; s_wlast = 4'b0001; m_wready = 1'b1;
    s_wdata[0 +: DATA_W] = 32'hDEAD_0000;
    #1;
    check_eq("t3_w_valid", 64'(m_wvalid), 64'd1);
    check_eq("t3_w_ready", 64'(s_wready), 64'b0001);
    check_eq("t3_w_data", 64'(m_wdata), 64'hDEAD_0000);
    tick();
    s_wvalid = '0; s_wlast = '0;
    #1;
    check_eq("t3_after_pop", 64'(outstanding), 64'd3);
    check_eq("t3_still_idle", 64'(m_awvalid), 64'd0);
    tick();
    gnt = '0;
    #1;
    check_eq("t3_late_accept", 64'(accept), 64'd1);
    check_eq("t3_late_awid", 64'(m_awid), 64'h0C);
    tick();
    check_eq("t3_refull", 64'(outstanding), 64'd4);
    m_awready = 1'b0; s_awvalid = '0; m_wready = 1'b0;

    // ---- AW order 2 then 0; W from both masters present early
    do_reset();
    s_wvalid = 4'b0101; m_wready = 1'b1;
    #1;
    check_eq("t4_w_blocked_valid", 64'(m_wvalid), 64'd0);
    check_eq("t4_w_blocked_ready", 64'(s_wready), 64'd0);
    m_wready = 1'b0;
    do_aw(2, 4'h2, 32'h2000, 8'd3);
    do_aw(0, 4'h0, 32'h0000, 8'd3);
    check_eq("t4_outstanding", 64'(outstanding), 64'd2);
    m_wready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_wdata[2*DATA_W +: DATA_W] = 32'h2222_0000 + 32'(b);
      s_wdata[0 +: DATA_W] = 32'h0000_1110 + 32'(b);
      s_wlast = (b == 3) ? 4'b0100 : 4'b0000;
      #1;
      check_eq($sformatf("t4_m2_data%0d", b), 64'(m_wdata), 64'(32'h2222_0000 + 32'(b)));
      check_eq($sformatf("t4_m2_ready%0d", b), 64'(s_wready), 64'b0100);
      check_eq($sformatf("t4_m2_last%0d", b), 64'(m_wlast), 64'(b == 3));
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      s_wdata[0 +: DATA_W] = 32'h0000_1110 + 32'(b);
      s_wlast = (b == 3) ? 4'b0001 : 4'b0000;
      #1;
      check_eq($sformatf("t4_m0_data%0d", b), 64'(m_wdata), 64'(32'h0000_1110 + 32'(b)));
      check_eq($sformatf("t4_m0_ready%0d", b), 64'(s_wready), 64'b0001);
      tick();
    end
    s_wvalid = '0; s_wlast = '0; m_wready = 1'b0;
    #1;
    check_eq("t4_drained", 64'(outstanding), 64'd0);

    // ---- Pop and push in the same cycle
    do_reset();
    do_aw(1, 4'h1, 32'h10, 8'd0);
    gnt = 4'b1000; s_awvalid = 4'b1000; m_awready = 1'b1;
    s_awid[3*ID_W +: ID_W] = 4'h3;
    tick();
    gnt = '0;
    s_wvalid = 4'b0010; s_wlast = 4'b0010; m_wready = 1'b1;
    #1;
    check_eq("t5_accept", 64'(accept), 64'd1);
    check_eq("t5_wvalid", 64'(m_wvalid), 64'd1);
    check_eq("t5_wready", 64'(s_wready), 64'b0010);
    tick();
    m_awready = 1'b0; s_awvalid = '0;
    s_wvalid = 4'b1000; s_wlast = 4'b1000;
    #1;
    check_eq("t5_outstanding", 64'(outstanding), 64'd1);
    check_eq("t5_new_head", 64'(s_wready), 64'b1000);
    s_wvalid = '0; s_wlast = '0; m_wready = 1'b0;

    // ---- Reset in the middle of a burst
    do_reset();
    do_aw(1, 4'h9, 32'h40, 8'd3);
    s_wvalid = 4'b0010; m_wready = 1'b1;
    tick();
    tick();
    check_eq("t6_mid_burst", 64'(s_wready), 64'b0010);
    rst_n = 1'b0;
    gnt = 4'b0010; s_awvalid = 4'b0010; m_awready = 1'b1;
    #1;
    check_eq("t6_during_wvalid", 64'(m_wvalid), 64'd0);
    check_eq("t6_during_wready", 64'(s_wready), 64'd0);
    check_eq("t6_during_outst", 64'(outstanding), 64'd0);
    tick();
    check_eq("t6_after_wvalid", 64'(m_wvalid), 64'd0);
    check_eq("t6_after_awvalid", 64'(m_awvalid), 64'd0);
    check_eq("t6_after_accept", 64'(accept), 64'd0);
    check_eq("t6_after_outst", 64'(outstanding), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("t6_release_wvalid", 64'(m_wvalid), 64'd0);
    check_eq("t6_release_idle", 64'(m_awvalid), 64'd0);
    tick();
    gnt = '0;
    #1;
    check_eq("t6_fresh_accept", 64'(accept), 64'd1);
    check_eq("t6_fresh_awid", 64'(m_awid), 64'h19);
    tick();
    check_eq("t6_fresh_outst", 64'(outstanding), 64'd1);
    check_eq("t6_fresh_wvalid", 64'(m_wvalid), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_aw_route_mux.md
Name: axi_aw_route_mux

Overview:
- Sits directly downstream of the interconnect's weighted round-robin arbiter, one instance per slave port.
- Converts the arbiter's combinational one-hot grant into a locked write-address channel selection.
- Forwards the selected master's AW beat to the slave and returns the arbiter's accept.
- Records the grant order in a route FIFO, which steers W-channel bursts from the matching masters in AW order.

Parameters:
- N, 4, number of upstream masters (matches arbiter N).
- ID_W, 4, per-master AWID width.
- ADDR_W, 32, address width.
- DATA_W, 32, W data width; strobe width is DATA_W/8.
- DEPTH, 4, route FIFO depth (max AW-accepted bursts whose W is not yet complete); power of two, ≥2.
- IDX_W, $clog2(N), master index width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- gnt  in  N  one-hot grant from arbiter.
- accept  out  1  to arbiter; high in the cycle the AW handshake completes.
- s_awvalid  in  N  per-master AW valid.
- s_awready  out  N  per-master AW ready.
- s_awid  in  N*ID_W  flattened per-master AWID, master i at bits [i*ID_W +: ID_W].
- s_awaddr  in  N*ADDR_W  flattened per-master address.
- s_awlen  in  N*8  flattened per-master burst length.
- m_awvalid  out  1  AW valid to slave.
- m_awready  in  1  AW ready from slave.
- m_awid  out  IDX_W+ID_W  {master index, s_awid}.
- m_awaddr  out  ADDR_W  forwarded address.
- m_awlen  out  8  forwarded length.
- s_wvalid  in  N  per-master W valid.
- s_wready  out  N  per-master W ready.
- s_wdata  in  N*DATA_W  flattened per-master W data.
- s_wstrb  in  N*DATA_W/8  flattened per-master W strobe.
- s_wlast  in  N  per-master W last.
- m_wvalid  out  1  W valid to slave.
- m_wready  in  1  W ready from slave.
- m_wdata  out  DATA_W  forwarded W data.
- m_wstrb  out  DATA_W/8  forwarded W strobe.
- m_wlast  out  1  forwarded W last.
- outstanding  out  $clog2(DEPTH+1)  route FIFO occupancy.

Behaviour:
- Reset (sync, rst_n low at a clk edge):
  - FSM goes to IDLE; sel=0; FIFO pointers and count go to 0.
  - All outputs are 0 during and after reset: accept, s_awready, m_awvalid, m_wvalid, s_wready, outstanding.
  - Reset mid-burst drops locked state and FIFO contents; no partial W is tracked afterwards.
- FSM IDLE:
  - Latch condition: gnt != 0 and count < DEPTH.
  - On latch: sel <= index of lowest set bit of gnt (non-one-hot gnt is tolerated); next state LOCKED.
  - gnt != 0 with FIFO full: stay IDLE; the grant is ignored (arbiter keeps requesting).
- FSM LOCKED:
  - m_awvalid = s_awvalid[sel]; m_awid/m_awaddr/m_awlen are muxed combinationally from sel.
  - s_awready[sel] = m_awready; all other s_awready bits are 0.
  - gnt is ignored while LOCKED.
  - On m_awvalid && m_awready:
    - accept = 1 for that cycle; push sel into FIFO; next state IDLE.
    - No back-to-back handshakes: at least one IDLE cycle separates AW transfers.
  - Latency: gnt seen at edge T gives LOCKED from T+1; earliest AW handshake and accept are in cycle T+1.
- Route FIFO:
  - Latching only with count < DEPTH, plus one pending push at most, guarantees no overflow.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- W steering (independent of the AW FSM):
  - If count > 0: wsel = FIFO head; m_wvalid = s_wvalid[wsel]; m_wdata/m_wstrb/m_wlast are muxed from wsel; s_wready[wsel] = m_wready; other s_wready bits are 0.
  - If count == 0: m_wvalid = 0 and all s_wready = 0. W before AW acceptance is blocked.
  - Pop on m_wvalid && m_wready && m_wlast.
  - A push into an empty FIFO makes W routable from the next cycle.
- Beat count and awlen are not checked; wlast alone terminates a burst.
- outstanding = count (registered).

Test Plan:
- Reset, then gnt=4'b0100 with s_awvalid[2]=1, m_awready=1 -> LOCKED next cycle; m_awid={2'd2,s_awid[2]}; accept=1 in that cycle; outstanding=1 the next cycle.
- Master 1 granted with m_awready low for 5 cycles while gnt switches to 4'b1000 -> sel stays 1; s_awready all 0; accept fires only on the first ready cycle; master 3 is not forwarded.
- Four AW from masters 0,1,2,3 without W (DEPTH=4) -> outstanding=4; a fifth gnt=4'b0001 is ignored (no LOCKED) until one W burst completes, then it latches.
- AW order 2 then 0, awlen=3, both masters present W early -> master 2's 4 beats are forwarded first; s_wready[0]=0 until m_wlast from master 2 is accepted.
- FIFO holds 1 entry; a W last pop coincides with a new AW push -> outstanding stays 1; the new head is the pushed index.
- rst_n low mid-burst (beat 2 of 4) -> the next cycle has all outputs 0, outstanding=0, FSM IDLE; a fresh grant works normally.
